// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter for RV32I SLL/SRL/SRA (and immediate forms).
// Shifts one bit position per clock instead of using a barrel shifter.
//
// Ports:
//   clk     rising-edge system clock
//   rst_n   synchronous active-low reset
//   start   request strobe, sampled only while idle
//   op      00 SLL, 01 SRL, 10 SRA, 11 reserved (passes a through)
//   a       operand (rs1)
//   shamt   shift amount
//   flush   synchronous abort from the pipeline
//   busy    high whenever an operation is in flight (SHIFT or DONE)
//   done    one-cycle pulse, result valid in that cycle
//   result  shifted value, held until the next accepted start
module iter_shift_unit #(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] shamt,
  input  logic           flush,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   work_q,  work_d;
  logic [SHW-1:0] cnt_q,   cnt_d;
  logic [1:0]     op_q,    op_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;

  // Next-state, working-register and status logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;

    unique case (state_q)
      S_IDLE: begin
        // flush alongside start rejects the request.
        if (start && !flush) begin
          work_d = a;
          op_d   = op;
          if ((shamt == '0) || (op == OP_RSV)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = shamt;
          end
        end
      end
      S_SHIFT: begin
        unique case (op_q)
          OP_SLL:  work_d = {work_q[N-2:0], 1'b0};
          OP_SRL:  work_d = {1'b0, work_q[N-1:1]};
          OP_SRA:  work_d = {work_q[N-1], work_q[N-1:1]};
          default: work_d = work_q;
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the operation without a done pulse and leaves result alone.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      work_d  = work_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  iter_shift_unit #(.N(32), .SHW(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   run   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain shift operators on the whole word.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] av, input logic [4:0] s);
    case (o)
      2'b00:   model = av << s;
      2'b01:   model = av >> s;
      2'b10:   model = 32'($signed(av) >>> s);
      default: model = av;
    endcase
  endfunction

  // Monitor: sample after each edge, pop on every done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (busy === 1'b1) run++;
    else               run = 0;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with result %h, expected no pulse (t=%0t)", result, $time);
      end else begin
        e = sbq.pop_front();
        chk("result",   result, e.res);
        chk("latency",  32'(cyc - e.e0), 32'(e.lat));
        chk("busy_len", 32'(run), 32'(e.lat + 1));
      end
    end
  end

  // Called at a falling edge; returns at the first falling edge with busy low.
  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, k);
    end
  endtask

  // Issue one operation; hold keeps start high with junk operands while busy.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [4:0] s, input int hold);
    exp_t e;
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = av;
    shamt = s;
    e.res = model(o, av, s);
    e.e0  = cyc + 1;
    e.lat = (s == 5'd0 || o == 2'b11) ? 0 : int'(s);
    sbq.push_back(e);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      a     = $urandom;
      shamt = 5'($urandom_range(0, 31));
      op    = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    shamt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", result,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(2'b00, 32'h0000_0001, 5'd4, 0);
    issue(2'b10, 32'h8000_0000, 5'd31, 0);
    issue(2'b01, 32'h8000_0000, 5'd31, 0);
    issue(2'b01, 32'hDEAD_BEEF, 5'd0, 0);
    issue(2'b11, 32'hDEAD_BEEF, 5'd7, 0);
    issue(2'b00, 32'h0000_0001, 5'd3, 3);
    issue(2'b01, 32'h1234_5678, 5'd1, 0);

    // Flush at count=2 of SRL 0xF0000000 >> 10
    issue(2'b01, 32'hF000_0000, 5'd10, 0);
    void'(sbq.pop_back());
    repeat (8) @(negedge clk);
    r = result;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy",   32'(busy), 32'd0);
    chk("flush_done",   32'(done), 32'd0);
    chk("flush_result", result,    r);
    issue(2'b10, 32'hF000_0000, 5'd4, 0);

    // flush together with start in IDLE rejects the request
    wait_idle();
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b00;
    a     = 32'h1;
    shamt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);

    // Reset mid-operation
    issue(2'b10, 32'h8000_0000, 5'd20, 0);
    void'(sbq.pop_back());
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_done",   32'(done), 32'd0);
    chk("midrst_result", result,    32'd0);
    issue(2'b10, 32'h8000_0000, 5'd1, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 0);
    end

    // Drain scoreboard
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results never arrived, expected 0 outstanding", sbq.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle iterative shifter for the RV32I shift instructions SLL/SRL/SRA and their immediate forms SLLI/SRLI/SRAI.
- Complements the datapath's fixed combinational shift-left blocks with right shifts (logical and arithmetic), plus variable-amount left shifts.
- Shifts one bit position per clock, so no barrel shifter is needed.
- Sits in the EX stage beside the ALU. While busy is high, the hazard unit stalls IF/ID/EX.

Parameters:
- N, 32, datapath width in bits.
- SHW, 5, shift-amount width; must equal log2(N).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- a  input  N  operand (rs1 value).
- shamt  input  SHW  shift amount (rs2[4:0] or imm[4:0]).
- flush  input  1  synchronous abort from the pipeline (branch mispredict / trap).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  N  shifted value; holds until the next accepted start.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n): asserted at a rising edge, it forces state IDLE, busy=0, done=0, result=0, internal count=0. This includes reset mid-operation.
- States:
  - IDLE: waiting for a request.
  - SHIFT: iterating one bit per cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Operand capture: on the edge where state=IDLE and start=1, latch a into the working register, and latch op and shamt. Let E0 be this edge.
- Transition at E0:
  - shamt=0 or op=11 → DONE.
  - Otherwise → SHIFT, with count=shamt.
- SHIFT, each edge:
  - SLL: reg = {reg[N-2:0],0}.
  - SRL: reg = {0,reg[N-1:1]}.
  - SRA: reg = {reg[N-1],reg[N-1:1]}. The sign replicates the original bit N-1, because the MSB is preserved each step.
  - count decrements by 1. When count reaches 0 on this edge, go to DONE.
- Latency:
  - done is high in the cycle after edge E(shamt); that is, shamt+1 edges counted inclusively from E0.
  - shamt=0 → done in the cycle right after E0.
  - shamt=31 → done after E31.
  - op=11 → latency 1 with result=a, regardless of shamt.
- result is driven from the working register. It is updated only during SHIFT/DONE and is stable from DONE until the next accepted start.
- Intermediate result values during SHIFT are not architecturally meaningful. Consumers use result only when done=1 or afterwards.
- busy = (state != IDLE); it is 1 in SHIFT and DONE. done = (state == DONE).
- start while not IDLE is ignored: no re-latch, no queueing. Back-to-back operations need at least one IDLE cycle, i.e. the next start is sampled no earlier than the edge after DONE.
- flush=1 at any edge with state≠IDLE: next state IDLE, count=0, no done pulse, result unchanged.
- flush=1 together with start=1 in IDLE: start is rejected; flush wins.
- rst_n=0 has priority over flush and start.
- Count uses the SHW-bit width; no overflow is possible since shamt ≤ N-1.

Test Plan:
- SLL: a=0x00000001, shamt=4, op=00 → done after E4 (5 edges), result=0x00000010, busy high for 5 cycles.
- SRA: a=0x80000000, shamt=31, op=10 → result=0xFFFFFFFF, done after E31. Then SRL with the same a and shamt → result=0x00000001.
- shamt=0: a=0xDEADBEEF, op=01 → done in the cycle after E0, result=0xDEADBEEF. op=11 with shamt=7 → result=0xDEADBEEF, latency 1.
- start held high with new operands while busy (a=0x1, shamt=3, SLL, then a=0xFF mid-op) → result=0x8, single done pulse. An op issued in the cycle after DONE is accepted normally.
- flush at SHIFT count=2 for SRL 0xF0000000 >> 10 → IDLE next cycle, no done, busy=0, result not used. start in the following cycle is accepted.
- rst_n low for one edge during SHIFT → busy=0, done=0, result=0x00000000 after that edge. A subsequent SRA of 0x80000000 by 1 gives 0xC0000000.
